// File: rtl/tmr_regfile_scrubber_if.sv
// rtl/tmr_regfile_scrubber_if.sv - scrubber control, stall handshake and replica bus
interface tmr_regfile_scrubber_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic              scrub_en;
  logic              force_scrub;
  logic              stall_req;
  logic              stall_ack;
  logic [ADDR_W-1:0] rf_addr;
  logic [DATA_W-1:0] rf_rdata_a;
  logic [DATA_W-1:0] rf_rdata_b;
  logic [DATA_W-1:0] rf_rdata_c;
  logic              rf_we;
  logic [DATA_W-1:0] rf_wdata;
  logic              busy;
  logic              scrub_done;
  logic [15:0]       err_count;
  logic              uncorrectable;
  logic [ADDR_W-1:0] fault_addr;

  // Scrubber side
  modport master (
    input  scrub_en, force_scrub, stall_ack, rf_rdata_a, rf_rdata_b, rf_rdata_c,
    output stall_req, rf_addr, rf_we, rf_wdata, busy, scrub_done,
    output err_count, uncorrectable, fault_addr
  );

  // Pipeline / register-file side
  modport slave (
    output scrub_en, force_scrub, stall_ack, rf_rdata_a, rf_rdata_b, rf_rdata_c,
    input  stall_req, rf_addr, rf_we, rf_wdata, busy, scrub_done,
    input  err_count, uncorrectable, fault_addr
  );
endinterface

// File: rtl/tmr_regfile_scrubber.sv
// rtl/tmr_regfile_scrubber.sv - periodic majority-vote scrubber for a triplicated register file
module tmr_regfile_scrubber #(
  parameter int NUM_REGS       = 32,
  parameter int ADDR_W         = 5,
  parameter int DATA_W         = 32,
  parameter int SCRUB_INTERVAL = 1024
) (
  input  logic                   clk_i,
  input  logic                   main_rst_ni,
  tmr_regfile_scrubber_if.master bus
);

  localparam int                CNT_W     = (SCRUB_INTERVAL > 2) ? $clog2(SCRUB_INTERVAL) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(SCRUB_INTERVAL - 1);
  localparam logic [ADDR_W-1:0] IDX_FIRST = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] IDX_LAST  = ADDR_W'(NUM_REGS - 1);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_SCAN, S_FIX, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] vote_q, vote_d;
  logic [15:0]       err_q, err_d;
  logic              unc_q, unc_d;
  logic [ADDR_W-1:0] fault_q, fault_d;

  logic [ADDR_W-1:0] rf_addr;
  logic [DATA_W-1:0] rf_wdata;
  logic              rf_we;
  logic              done;

  logic [DATA_W-1:0] a, b, c, vote;
  logic              all_eq, all_diff, at_last;

  assign a        = bus.rf_rdata_a;
  assign b        = bus.rf_rdata_b;
  assign c        = bus.rf_rdata_c;
  assign vote     = (a & b) | (a & c) | (b & c);
  assign all_eq   = (a == b) && (b == c);
  assign all_diff = (a != b) && (b != c) && (a != c);
  assign at_last  = (idx_q == IDX_LAST);

  // State and bookkeeping registers; a reset abandons any pass in flight
  always_ff @(posedge clk_i or negedge main_rst_ni) begin
    if (!main_rst_ni) begin
      state_q <= S_IDLE;
      idx_q   <= IDX_FIRST;
      cnt_q   <= '0;
      vote_q  <= '0;
      err_q   <= '0;
      unc_q   <= 1'b0;
      fault_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      vote_q  <= vote_d;
      err_q   <= err_d;
      unc_q   <= unc_d;
      fault_q <= fault_d;
    end
  end

  // Next-state and replica-bus drive; losing stall_ack parks in REQ with idx held
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    vote_d   = vote_q;
    err_d    = err_q;
    unc_d    = unc_q;
    fault_d  = fault_q;
    rf_addr  = '0;
    rf_wdata = '0;
    rf_we    = 1'b0;
    done     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.force_scrub || (bus.scrub_en && (cnt_q == CNT_LAST))) begin
          cnt_d   = '0;
          state_d = S_REQ;
        end else if (bus.scrub_en) begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_REQ: begin
        if (bus.stall_ack) state_d = S_SCAN;
      end

      S_SCAN: begin
        rf_addr = idx_q;
        if (!bus.stall_ack) begin
          state_d = S_REQ;
        end else if (all_eq || all_diff) begin
          // No majority on a 3-way split: flag it and leave the replicas alone
          if (all_diff) begin
            unc_d   = 1'b1;
            fault_d = idx_q;
          end
          if (at_last) begin
            state_d = S_DONE;
            idx_d   = IDX_FIRST;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          vote_d  = vote;
          fault_d = idx_q;
          state_d = S_FIX;
        end
      end

      S_FIX: begin
        rf_addr  = idx_q;
        rf_wdata = vote_q;
        if (!bus.stall_ack) begin
          // Write dropped; the word is re-read and re-voted after re-ack
          state_d = S_REQ;
        end else begin
          rf_we = 1'b1;
          if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
          if (at_last) begin
            state_d = S_DONE;
            idx_d   = IDX_FIRST;
          end else begin
            state_d = S_SCAN;
            idx_d   = idx_q + 1'b1;
          end
        end
      end

      S_DONE: begin
        done    = 1'b1;
        idx_d   = IDX_FIRST;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign bus.busy          = (state_q != S_IDLE);
  assign bus.stall_req     = (state_q != S_IDLE);
  assign bus.rf_addr       = rf_addr;
  assign bus.rf_we         = rf_we;
  assign bus.rf_wdata      = rf_wdata;
  assign bus.scrub_done    = done;
  assign bus.err_count     = err_q;
  assign bus.uncorrectable = unc_q;
  assign bus.fault_addr    = fault_q;

endmodule

// File: tb/tb_tmr_regfile_scrubber.sv
// tb/tb_tmr_regfile_scrubber.sv - directed bench for tmr_regfile_scrubber
`timescale 1ns/1ps
module tb_tmr_regfile_scrubber;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  tmr_regfile_scrubber_if #(.ADDR_W(5), .DATA_W(32)) bus ();

  tmr_regfile_scrubber #(
    .NUM_REGS(32), .ADDR_W(5), .DATA_W(32), .SCRUB_INTERVAL(1024)
  ) dut (
    .clk_i       (clk),
    .main_rst_ni (rst_n),
    .bus         (bus.master)
  );

  logic [31:0] mem_a [32];
  logic [31:0] mem_b [32];
  logic [31:0] mem_c [32];

  always_comb begin
    bus.rf_rdata_a = mem_a[bus.rf_addr];
    bus.rf_rdata_b = mem_b[bus.rf_addr];
    bus.rf_rdata_c = mem_c[bus.rf_addr];
  end

  int errors = 0;
  int checks = 0;
  int sreq_cnt, we_cnt, we3_cnt, done_cnt;
  logic [4:0]  last_we_addr;
  logic [31:0] last_we_data;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    logic [31:0] agg;
    agg = {16'(bus.err_count), 5'(bus.rf_addr), 5'(bus.fault_addr), bus.stall_req, bus.busy,
           bus.rf_we, bus.scrub_done, bus.uncorrectable, |bus.rf_wdata};
    check(tag, agg, 32'h0);
  endtask

  task automatic clear_counts();
    sreq_cnt = 0; we_cnt = 0; we3_cnt = 0; done_cnt = 0;
    last_we_addr = '0; last_we_data = '0;
  endtask

  // One clock: capture the write strobe before the edge, apply it to all replicas on the edge
  task automatic tick();
    logic        cwe;
    logic [4:0]  caddr;
    logic [31:0] cdata;
    @(negedge clk);
    cwe = bus.rf_we; caddr = bus.rf_addr; cdata = bus.rf_wdata;
    if (cwe) begin
      we_cnt++;
      last_we_addr = caddr;
      last_we_data = cdata;
      if (caddr == 5'd3) we3_cnt++;
    end
    @(posedge clk);
    if (cwe) begin
      mem_a[caddr] = cdata;
      mem_b[caddr] = cdata;
      mem_c[caddr] = cdata;
    end
    #1;
    if (bus.stall_req)  sreq_cnt++;
    if (bus.scrub_done) done_cnt++;
  endtask

  task automatic force_pulse();
    bus.force_scrub = 1'b1;
    tick();
    bus.force_scrub = 1'b0;
  endtask

  task automatic wait_addr(input logic [4:0] a, input int limit, input string tag);
    int n;
    n = 0;
    while (bus.rf_addr !== a && n < limit) begin
      tick();
      n++;
    end
    check(tag, 32'(bus.rf_addr), 32'(a));
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    bus.scrub_en = 1'b0;
    bus.force_scrub = 1'b0;
    bus.stall_ack = 1'b0;
    for (int i = 0; i < 32; i++) begin
      mem_a[i] = 32'h1000_0000 + i;
      mem_b[i] = 32'h1000_0000 + i;
      mem_c[i] = 32'h1000_0000 + i;
    end
    clear_counts();

    // 1. reset state, then idle with scrub_en=0
    #2;
    check_all_zero("reset_outputs");
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2000) tick();
    check("idle_no_stall", 32'(sreq_cnt), 32'd0);

    // 2. clean forced pass
    bus.stall_ack = 1'b1;
    clear_counts();
    force_pulse();
    check("clean_stall_rise", 32'(bus.stall_req), 32'd1);
    repeat (40) tick();
    check("clean_stall_cycles", 32'(sreq_cnt), 32'd33);
    check("clean_no_we", 32'(we_cnt), 32'd0);
    check("clean_done_pulses", 32'(done_cnt), 32'd1);
    check("clean_err_count", 32'(bus.err_count), 32'd0);
    check("clean_idle", 32'(bus.busy), 32'd0);

    // 3. single upset in replica B at x7
    mem_a[7] = 32'h1234_5678;
    mem_b[7] = 32'hDEAD_BEEF;
    mem_c[7] = 32'h1234_5678;
    clear_counts();
    force_pulse();
    repeat (45) tick();
    check("fix_stall_cycles", 32'(sreq_cnt), 32'd34);
    check("fix_we_count", 32'(we_cnt), 32'd1);
    check("fix_we_addr", 32'(last_we_addr), 32'd7);
    check("fix_we_data", last_we_data, 32'h1234_5678);
    check("fix_err_count", 32'(bus.err_count), 32'd1);
    check("fix_fault_addr", 32'(bus.fault_addr), 32'd7);
    check("fix_replica_b", mem_b[7], 32'h1234_5678);
    check("fix_not_uncorr", 32'(bus.uncorrectable), 32'd0);

    // 4. three-way disagreement at x3
    mem_a[3] = 32'd1;
    mem_b[3] = 32'd2;
    mem_c[3] = 32'd4;
    clear_counts();
    force_pulse();
    repeat (45) tick();
    check("tri_stall_cycles", 32'(sreq_cnt), 32'd33);
    check("tri_no_we_x3", 32'(we3_cnt), 32'd0);
    check("tri_uncorr", 32'(bus.uncorrectable), 32'd1);
    check("tri_err_count", 32'(bus.err_count), 32'd1);
    check("tri_fault_addr", 32'(bus.fault_addr), 32'd3);
    mem_a[3] = 32'd3;
    mem_b[3] = 32'd3;
    mem_c[3] = 32'd3;
    clear_counts();
    force_pulse();
    repeat (45) tick();
    check("tri_done_again", 32'(done_cnt), 32'd1);
    check("tri_uncorr_sticky", 32'(bus.uncorrectable), 32'd1);
    check("tri_err_unchanged", 32'(bus.err_count), 32'd1);

    // 5. periodic trigger and stall_ack drop at idx 10
    rst_n = 1'b0;
    #2;
    check_all_zero("reset2_outputs");
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.scrub_en = 1'b1;
    clear_counts();
    n = 0;
    do begin
      tick();
      n++;
    end while (!bus.stall_req && n < 1100);
    check("periodic_latency", 32'(n), 32'd1024);
    wait_addr(5'd10, 100, "reach_idx10");
    bus.stall_ack = 1'b0;
    tick();
    check("drop_addr_parked", 32'(bus.rf_addr), 32'd0);
    repeat (4) tick();
    check("drop_stall_held", 32'(bus.stall_req), 32'd1);
    bus.stall_ack = 1'b1;
    tick();
    check("resume_addr", 32'(bus.rf_addr), 32'd10);
    repeat (40) tick();
    bus.scrub_en = 1'b0;
    check("periodic_stall_cycles", 32'(sreq_cnt), 32'd39);
    check("periodic_done", 32'(done_cnt), 32'd1);
    check("periodic_no_we", 32'(we_cnt), 32'd0);

    // 6. asynchronous reset mid-scan at idx 15
    mem_b[5] = mem_b[5] ^ 32'h1;
    clear_counts();
    force_pulse();
    wait_addr(5'd15, 100, "reach_idx15");
    check("pre_reset_err", 32'(bus.err_count), 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset_outputs");
    @(posedge clk); #1;
    rst_n = 1'b1;
    force_pulse();
    check("restart_req", 32'(bus.stall_req), 32'd1);
    tick();
    check("restart_idx1", 32'(bus.rf_addr), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
